// File: rtl/skew_capture_sequencer_pkg.sv
// Shared definitions for the skew capture sequencer: FSM state encoding and
// default channel/skew widths.
package skew_capture_sequencer_pkg;

  localparam int unsigned DATA_W_DEF = 1;
  localparam int unsigned SKEW_W_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CAP1 = 3'd1,
    S_WAIT = 3'd2,
    S_CAP2 = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/skew_capture_sequencer_delay_counter.sv
// Loadable down-counter that times the gap between the two captures.
// It saturates at zero, so a full-scale delay can never wrap.
module skew_delay_counter #(
  parameter int SKEW_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [SKEW_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  localparam logic [SKEW_W-1:0] CNT_ONE = SKEW_W'(1);

  logic [SKEW_W-1:0] cnt_q;
  logic [SKEW_W-1:0] cnt_d;

  // Next count: a load wins over a decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/skew_capture_sequencer.sv
// Captures channel 1, waits a programmable skew, captures channel 2 and flags
// whether the two captured words differ. Every output is a flop.
module skew_capture_sequencer
  import skew_capture_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SKEW_W = SKEW_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [SKEW_W-1:0] skew_cfg,
  input  logic [DATA_W-1:0] d_in1,
  input  logic [DATA_W-1:0] d_in2,
  output logic [DATA_W-1:0] q_out1,
  output logic [DATA_W-1:0] q_out2,
  output logic              cap_en1,
  output logic              cap_en2,
  output logic              busy,
  output logic              done,
  output logic              mismatch
);

  localparam logic [SKEW_W-1:0] SKEW_ONE = SKEW_W'(1);

  state_e            state_q, state_d;
  logic [SKEW_W-1:0] skew_q, skew_d;
  logic [DATA_W-1:0] q_out1_q, q_out1_d;
  logic [DATA_W-1:0] q_out2_q, q_out2_d;
  logic              cap_en1_q, cap_en1_d;
  logic              cap_en2_q, cap_en2_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mismatch_q, mismatch_d;
  logic              cnt_load_s;
  logic              cnt_dec_s;
  logic              cnt_zero_s;

  skew_delay_counter #(.SKEW_W(SKEW_W)) u_delay_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load_s),
    .load_val (skew_q - SKEW_ONE),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // Next-state, capture and compare logic; pulse flags are decoded from the
  // next state so they line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    skew_d     = skew_q;
    q_out1_d   = q_out1_q;
    q_out2_d   = q_out2_q;
    mismatch_d = mismatch_q;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CAP1;
          skew_d     = skew_cfg;
          mismatch_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CAP1: begin
        q_out1_d = d_in1;
        if (skew_q == '0) begin
          state_d = S_CAP2;
        end else begin
          state_d    = S_WAIT;
          cnt_load_s = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_zero_s) begin
          state_d = S_CAP2;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      S_CAP2: begin
        q_out2_d   = d_in2;
        mismatch_d = (q_out1_q != d_in2);
        state_d    = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    cap_en1_d = (state_d == S_CAP1);
    cap_en2_d = (state_d == S_CAP2);
    done_d    = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);
  end

  // State, capture and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      skew_q     <= '0;
      q_out1_q   <= '0;
      q_out2_q   <= '0;
      cap_en1_q  <= 1'b0;
      cap_en2_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skew_q     <= skew_d;
      q_out1_q   <= q_out1_d;
      q_out2_q   <= q_out2_d;
      cap_en1_q  <= cap_en1_d;
      cap_en2_q  <= cap_en2_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign q_out1   = q_out1_q;
  assign q_out2   = q_out2_q;
  assign cap_en1  = cap_en1_q;
  assign cap_en2  = cap_en2_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_skew_capture_sequencer.sv
// Directed self-checking bench for skew_capture_sequencer (DATA_W=8, SKEW_W=4).
// Inputs change and outputs are sampled on the falling edge, mid-cycle.
module tb_skew_capture_sequencer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [3:0] skew_cfg;
  logic [7:0] d_in1;
  logic [7:0] d_in2;
  logic [7:0] q_out1;
  logic [7:0] q_out2;
  logic       cap_en1;
  logic       cap_en2;
  logic       busy;
  logic       done;
  logic       mismatch;

  int checks = 0;
  int errors = 0;

  skew_capture_sequencer #(.DATA_W(8), .SKEW_W(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .skew_cfg (skew_cfg),
    .d_in1    (d_in1),
    .d_in2    (d_in2),
    .q_out1   (q_out1),
    .q_out2   (q_out2),
    .cap_en1  (cap_en1),
    .cap_en2  (cap_en2),
    .busy     (busy),
    .done     (done),
    .mismatch (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_q_out1"}, q_out1, 32'd0);
    chk({tag, "_q_out2"}, q_out2, 32'd0);
    chk({tag, "_cap_en1"}, cap_en1, 32'd0);
    chk({tag, "_cap_en2"}, cap_en2, 32'd0);
    chk({tag, "_busy"}, busy, 32'd0);
    chk({tag, "_done"}, done, 32'd0);
    chk({tag, "_mismatch"}, mismatch, 32'd0);
  endtask

  // Call with start already high ahead of the accepting edge E0. Walks cycles
  // 1..n+3 and checks the pulse pattern; returns mid-cycle n+3 (DONE).
  task automatic seq_check(input string tag, input int n, input bit hold,
                           input int d2_cyc, input logic [7:0] d2_val,
                           input int sk_cyc, input logic [3:0] sk_val);
    for (int c = 1; c <= n + 3; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (c == d2_cyc) d_in2 = d2_val;
      if (c == sk_cyc) skew_cfg = sk_val;
      chk({tag, "_cap_en1"}, cap_en1, 32'(c == 1));
      chk({tag, "_cap_en2"}, cap_en2, 32'(c == n + 2));
      chk({tag, "_done"}, done, 32'(c == n + 3));
      chk({tag, "_busy"}, busy, 32'd1);
      if (c <= n + 2) chk({tag, "_mismatch_cleared"}, mismatch, 32'd0);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    skew_cfg = 4'd0;
    d_in1    = 8'h00;
    d_in2    = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");

    // 1: N=0, equal data
    d_in1 = 8'h01; d_in2 = 8'h01; skew_cfg = 4'd0; start = 1'b1;
    seq_check("t1", 0, 1'b0, 0, 8'h00, 0, 4'd0);
    chk("t1_q_out1", q_out1, 32'h01);
    chk("t1_q_out2", q_out2, 32'h01);
    chk("t1_mismatch", mismatch, 32'd0);
    @(negedge clk);
    chk("t1_idle_busy", busy, 32'd0);

    // 2: N=5, channel 2 changes in cycle 4
    d_in1 = 8'hA5; d_in2 = 8'hA5; skew_cfg = 4'd5; start = 1'b1;
    seq_check("t2", 5, 1'b0, 4, 8'h3C, 0, 4'd0);
    chk("t2_q_out1", q_out1, 32'hA5);
    chk("t2_q_out2", q_out2, 32'h3C);
    chk("t2_mismatch", mismatch, 32'd1);
    @(negedge clk);
    chk("t2_mismatch_hold", mismatch, 32'd1);
    chk("t2_q_out1_hold", q_out1, 32'hA5);

    // 3: N=15, full-scale delay
    d_in1 = 8'h11; d_in2 = 8'h11; skew_cfg = 4'd15; start = 1'b1;
    seq_check("t3", 15, 1'b0, 0, 8'h00, 0, 4'd0);
    chk("t3_q_out2", q_out2, 32'h11);
    chk("t3_mismatch", mismatch, 32'd0);
    @(negedge clk);
    chk("t3_busy_after", busy, 32'd0);
    chk("t3_done_after", done, 32'd0);

    // 4: start held high, N=2: accepted at E0 and E6 only
    d_in1 = 8'h22; d_in2 = 8'h22; skew_cfg = 4'd2; start = 1'b1;
    seq_check("t4a", 2, 1'b1, 0, 8'h00, 0, 4'd0);
    @(negedge clk);
    chk("t4_c6_busy", busy, 32'd0);
    chk("t4_c6_cap_en1", cap_en1, 32'd0);
    seq_check("t4b", 2, 1'b0, 0, 8'h00, 0, 4'd0);
    @(negedge clk);
    chk("t4_c12_busy", busy, 32'd0);

    // 5: reset in WAIT of an N=7 run
    d_in1 = 8'h77; d_in2 = 8'h77; skew_cfg = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_cap_en1", cap_en1, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t5_wait_busy", busy, 32'd1);
    chk("t5_wait_q_out1", q_out1, 32'h77);
    reset_n = 1'b0;
    #1;
    chk_all_zero("t5_async");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t5_no_done", done, 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    d_in1 = 8'h5A; d_in2 = 8'h5A; skew_cfg = 4'd1; start = 1'b1;
    seq_check("t5_clean", 1, 1'b0, 0, 8'h00, 0, 4'd0);
    chk("t5_clean_q_out1", q_out1, 32'h5A);
    chk("t5_clean_q_out2", q_out2, 32'h5A);
    chk("t5_clean_mismatch", mismatch, 32'd0);
    @(negedge clk);

    // 6: skew_cfg 3->9 in cycle 2 does not disturb the running sequence
    d_in1 = 8'h66; d_in2 = 8'h66; skew_cfg = 4'd3; start = 1'b1;
    seq_check("t6a", 3, 1'b0, 0, 8'h00, 2, 4'd9);
    @(negedge clk);
    start = 1'b1;
    seq_check("t6b", 9, 1'b0, 0, 8'h00, 0, 4'd0);
    chk("t6_q_out2", q_out2, 32'h66);
    @(negedge clk);
    chk("t6_busy_after", busy, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
